// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The slave modport is the adder's view and the master modport is the producer/consumer view.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Stage 1 registers bit and group generate/propagate; stage 2 resolves the carries and the flags.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned NG = WIDTH / GROUP;

    if (GROUP != 4) begin : g_bad_group
        $error("cla_pipe_adder: GROUP must be 4");
    end
    if ((WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    // Carry into position n as a flat sum of products: G[n-1] | P[n-1]G[n-2] | ... | P[n-1..0]c.
    function automatic logic la_carry(input logic [15:0] gv, input logic [15:0] pv,
                                      input logic c, input int unsigned n);
        logic res;
        logic prod;
        res = c;
        for (int unsigned m = 0; m < n; m++) res = res & pv[m[3:0]];
        for (int unsigned j = 0; j < n; j++) begin
            prod = gv[j[3:0]];
            for (int unsigned m = j + 1; m < n; m++) prod = prod & pv[m[3:0]];
            res = res | prod;
        end
        return res;
    endfunction

    logic             s2_adv;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             c0_d;
    logic [WIDTH-1:0] g_d, p_d;
    logic [NG-1:0]    gg_d, gp_d;
    logic             s1_valid_q;
    logic [WIDTH-1:0] g_q, p_q;
    logic [NG-1:0]    gg_q, gp_q;
    logic             c0_q, amsb_q, bmsb_q;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, ovf_d, zero_d;
    logic             out_valid_q, cout_q, ovf_q, zero_q;

    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        b_eff = bus.sub ? ~bus.b : bus.b;
        c0_d  = bus.sub | bus.cin;
        g_d   = bus.a & b_eff;
        p_d   = bus.a ^ b_eff;
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        assign gg_d[k] = la_carry(16'(g_d[GROUP*k +: GROUP]), 16'(p_d[GROUP*k +: GROUP]), 1'b0, GROUP);
        assign gp_d[k] = &p_d[GROUP*k +: GROUP];
    end

    for (genvar k = 0; k <= NG; k++) begin : g_gcarry
        assign gc[k] = la_carry(16'(gg_q), 16'(gp_q), c0_q, k);
    end

    for (genvar k = 0; k < NG; k++) begin : g_bcarry
        for (genvar i = 0; i < GROUP; i++) begin : g_bit
            assign carry[GROUP*k + i] =
                la_carry(16'(g_q[GROUP*k +: GROUP]), 16'(p_q[GROUP*k +: GROUP]), gc[k], i);
        end
    end

    always_comb begin
        sum_d  = p_q ^ carry;
        cout_d = gc[NG];
        ovf_d  = (amsb_q == bmsb_q) && (sum_d[WIDTH-1] != amsb_q);
        zero_d = (sum_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            g_q         <= '0;
            p_q         <= '0;
            gg_q        <= '0;
            gp_q        <= '0;
            c0_q        <= 1'b0;
            amsb_q      <= 1'b0;
            bmsb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                g_q        <= g_d;
                p_q        <= p_d;
                gg_q       <= gg_d;
                gp_q       <= gp_d;
                c0_q       <= c0_d;
                amsb_q     <= bus.a[WIDTH-1];
                bmsb_q     <= b_eff[WIDTH-1];
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end
            // Result registers only move on advance, so they stay frozen during a stall.
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and model-based checks of cla_pipe_adder at widths 32, 4 and 64.
module tb_cla_pipe_adder;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    cla_pipe_adder_if #(.WIDTH(32)) bus32 ();
    cla_pipe_adder_if #(.WIDTH(4))  bus4 ();
    cla_pipe_adder_if #(.WIDTH(64)) bus64 ();

    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) u32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    cla_pipe_adder #(.WIDTH(4),  .GROUP(4)) u4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    cla_pipe_adder #(.WIDTH(64), .GROUP(4)) u64 (.clk(clk), .rst(rst), .bus(bus64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t ref_model(input int unsigned n, input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input logic sub);
        exp_t        e;
        logic [64:0] mask, full;
        logic [63:0] am, be;
        mask   = (65'd1 << n) - 65'd1;
        am     = a & mask[63:0];
        be     = (sub ? ~b : b) & mask[63:0];
        full   = {1'b0, am} + {1'b0, be} + {64'd0, (sub ? 1'b1 : cin)};
        e.s    = full[63:0] & mask[63:0];
        e.co   = full[n];
        e.ov   = (am[n-1] == be[n-1]) && (e.s[n-1] != am[n-1]);
        e.z    = (e.s == 64'd0);
        return e;
    endfunction

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bus32.a        = a;
        bus32.b        = b;
        bus32.cin      = cin;
        bus32.sub      = sub;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        bus32.in_valid = 1'b1;
        bus32.a        = 32'hFFFF_FFFF;
        bus32.b        = 32'h0000_0001;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_out_valid got=%b want=0", bus32.out_valid); end
        n_cmp++; if (bus32.sum !== 32'd0) begin n_mis++; $display("FAIL rst_sum got=%h want=00000000", bus32.sum); end
        n_cmp++; if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b000) begin n_mis++; $display("FAIL rst_flags got=%b want=000", {bus32.cout, bus32.ovf, bus32.zero}); end
        n_cmp++; if ({bus4.out_valid, bus64.out_valid} !== 2'b00) begin n_mis++; $display("FAIL rst_out_valid_4_64 got=%b want=00", {bus4.out_valid, bus64.out_valid}); end
        bus32.in_valid = 1'b0;
        rst            = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus32.in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_in_ready got=%b want=1", bus32.in_ready); end
        repeat (2) @(negedge clk);
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_no_stale_result got=%b want=0", bus32.out_valid); end
    endtask

    task automatic test_carry_chain;
        bus32.a        = 32'hFFFF_FFFF;
        bus32.b        = 32'h0000_0001;
        bus32.cin      = 1'b0;
        bus32.sub      = 1'b0;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL chain_early_valid got=%b want=0", bus32.out_valid); end
        @(negedge clk);
        n_cmp++; if (bus32.out_valid !== 1'b1) begin n_mis++; $display("FAIL chain_latency got=%b want=1", bus32.out_valid); end
        n_cmp++; if ({bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== {32'h0, 1'b1, 1'b0, 1'b1})
            begin n_mis++; $display("FAIL chain_result got=%h/%b%b%b want=00000000/101", bus32.sum, bus32.cout, bus32.ovf, bus32.zero); end
        @(negedge clk);
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL chain_single_result got=%b want=0", bus32.out_valid); end
    endtask

    task automatic test_directed;
        vec_t v [8];
        v[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        v[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        v[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        v[3] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        v[4] = '{32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0, 1'b0};
        v[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        v[6] = '{32'h1234_5678, 32'h0EDC_BA98, 1'b0, 1'b0, 32'h2111_1110, 1'b0, 1'b0, 1'b0};
        v[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive32(v[i].a, v[i].b, v[i].cin, v[i].sub);
            n_cmp++; if (bus32.out_valid !== 1'b1) begin n_mis++; $display("FAIL dir%0d_valid got=%b want=1", i, bus32.out_valid); end
            n_cmp++; if ({bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== {v[i].s, v[i].co, v[i].ov, v[i].z})
                begin n_mis++; $display("FAIL dir%0d_result got=%h/%b%b%b want=%h/%b%b%b", i, bus32.sum, bus32.cout, bus32.ovf, bus32.zero, v[i].s, v[i].co, v[i].ov, v[i].z); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        exp_t q[$];
        for (int j = 0; j < 102; j++) begin
            if (j >= 2) begin
                e = q.pop_front();
                n_cmp++; if (bus32.out_valid !== 1'b1) begin n_mis++; $display("FAIL b2b%0d_valid got=%b want=1", j - 2, bus32.out_valid); end
                n_cmp++; if ({bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== {e.s[31:0], e.co, e.ov, e.z})
                    begin n_mis++; $display("FAIL b2b%0d_result got=%h/%b%b%b want=%h/%b%b%b", j - 2, bus32.sum, bus32.cout, bus32.ovf, bus32.zero, e.s[31:0], e.co, e.ov, e.z); end
            end
            if (j < 100) begin
                bus32.a        = (j % 10 == 3) ? 32'hFFFF_FFFF : $urandom;
                bus32.b        = (j % 10 == 7) ? 32'h0000_0000 : $urandom;
                bus32.cin      = 1'($urandom_range(1, 0));
                bus32.sub      = 1'($urandom_range(1, 0));
                bus32.in_valid = 1'b1;
                q.push_back(ref_model(32, {32'd0, bus32.a}, {32'd0, bus32.b}, bus32.cin, bus32.sub));
            end else begin
                bus32.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_drained got=%b want=0", bus32.out_valid); end
    endtask

    task automatic test_stall;
        bus32.out_ready = 1'b0;
        bus32.a = 32'd1; bus32.b = 32'd2; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.in_valid = 1'b1;
        #1;
        n_cmp++; if (bus32.in_ready !== 1'b1) begin n_mis++; $display("FAIL stall_ready_empty got=%b want=1", bus32.in_ready); end
        @(negedge clk);
        bus32.a = 32'd10; bus32.b = 32'd3; bus32.sub = 1'b1;
        n_cmp++; if (bus32.in_ready !== 1'b1) begin n_mis++; $display("FAIL stall_ready_one got=%b want=1", bus32.in_ready); end
        @(negedge clk);
        bus32.a = 32'hFFFF_0000; bus32.b = 32'h0000_FFFF; bus32.cin = 1'b1; bus32.sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus32.in_ready !== 1'b0) begin n_mis++; $display("FAIL stall%0d_in_ready got=%b want=0", i, bus32.in_ready); end
            n_cmp++; if ({bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== {1'b1, 32'd3, 3'b000})
                begin n_mis++; $display("FAIL stall%0d_hold got=%b/%h/%b%b%b want=1/00000003/000", i, bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero); end
            if (i < 3) @(negedge clk);
        end
        bus32.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus32.in_ready !== 1'b1) begin n_mis++; $display("FAIL stall_release_ready got=%b want=1", bus32.in_ready); end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        n_cmp++; if ({bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== {1'b1, 32'd7, 3'b100})
            begin n_mis++; $display("FAIL stall_second got=%b/%h/%b%b%b want=1/00000007/100", bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero); end
        @(negedge clk);
        n_cmp++; if ({bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== {1'b1, 32'd0, 3'b101})
            begin n_mis++; $display("FAIL stall_third got=%b/%h/%b%b%b want=1/00000000/101", bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero); end
        @(negedge clk);
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL stall_drained got=%b want=0", bus32.out_valid); end
    endtask

    task automatic test_reset_mid;
        bus32.a = 32'd4; bus32.b = 32'd4; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.a = 32'd9;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        n_cmp++; if (bus32.out_valid !== 1'b1) begin n_mis++; $display("FAIL midrst_pre got=%b want=1", bus32.out_valid); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL midrst_async got=%b want=0", bus32.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus32.out_valid !== 1'b0) begin n_mis++; $display("FAIL midrst_drop%0d got=%b want=0", i, bus32.out_valid); end
        end
    endtask

    task automatic test_width4_exhaustive;
        exp_t       e;
        exp_t       q[$];
        logic [9:0] v;
        for (int j = 0; j < 1026; j++) begin
            if (j >= 2) begin
                e = q.pop_front();
                n_cmp++; if ({bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf, bus4.zero} !== {1'b1, e.s[3:0], e.co, e.ov, e.z})
                    begin n_mis++; $display("FAIL w4_%0d got=%b/%h/%b%b%b want=1/%h/%b%b%b", j - 2, bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf, bus4.zero, e.s[3:0], e.co, e.ov, e.z); end
            end
            if (j < 1024) begin
                v             = 10'(j);
                bus4.a        = v[3:0];
                bus4.b        = v[7:4];
                bus4.cin      = v[8];
                bus4.sub      = v[9];
                bus4.in_valid = 1'b1;
                q.push_back(ref_model(4, {60'd0, v[3:0]}, {60'd0, v[7:4]}, v[8], v[9]));
            end else begin
                bus4.in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_width64_random;
        exp_t e;
        exp_t q[$];
        for (int j = 0; j < 202; j++) begin
            if (j >= 2) begin
                e = q.pop_front();
                n_cmp++; if ({bus64.out_valid, bus64.sum, bus64.cout, bus64.ovf, bus64.zero} !== {1'b1, e.s, e.co, e.ov, e.z})
                    begin n_mis++; $display("FAIL w64_%0d got=%b/%h/%b%b%b want=1/%h/%b%b%b", j - 2, bus64.out_valid, bus64.sum, bus64.cout, bus64.ovf, bus64.zero, e.s, e.co, e.ov, e.z); end
            end
            if (j < 200) begin
                bus64.a        = (j % 8 == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                bus64.b        = (j % 8 == 1) ? 64'd1 : {$urandom, $urandom};
                bus64.cin      = 1'($urandom_range(1, 0));
                bus64.sub      = 1'($urandom_range(1, 0));
                bus64.in_valid = 1'b1;
                q.push_back(ref_model(64, bus64.a, bus64.b, bus64.cin, bus64.sub));
            end else begin
                bus64.in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.sub  = 1'b0; bus4.out_ready  = 1'b1;
        bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.cin = 1'b0; bus64.sub = 1'b0; bus64.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_carry_chain();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_width4_exhaustive();
        test_width64_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
